pipeline_stall_ctrl: RTL and testbench

Central sequencing controller for the five-stage LC-3b pipeline. Generates the `load` and bubble/flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. Holds the whole pipeline on instruction- or data-memory waits and buffers whichever memory response arrives first. Inserts a load-use bubble and squashes wrong-path instructions on a taken branch resolved in MEM.

---
 rtl/pipeline_stall_ctrl_if.sv | 47 ++++
 rtl/pipeline_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_if.sv
// Bus bundle between the LC-3b pipeline datapath/memories and the stall controller.
interface pipeline_stall_ctrl_if;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 32;

  logic              imem_resp;
  logic [WORD_W-1:0] imem_rdata;
  logic              imem_read;
  logic [WORD_W-1:0] fetch_instr;
  logic              mem_read_req;
  logic              mem_write_req;
  logic              dmem_resp;
  logic [WORD_W-1:0] dmem_rdata;
  logic              dmem_read;
  logic              dmem_write;
  logic [WORD_W-1:0] mem_rdata;
  logic              load_use;
  logic              branch_taken;
  logic              load_pc;
  logic              load_ifid;
  logic              load_idex;
  logic              load_exmem;
  logic              load_memwb;
  logic              pcmux_redirect;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic [CNT_W-1:0]  stall_cycles;

  // Controller side: consumes memory/hazard status, drives strobes.
  modport master (
    input  imem_resp, imem_rdata, mem_read_req, mem_write_req,
           dmem_resp, dmem_rdata, load_use, branch_taken,
    output imem_read, fetch_instr, dmem_read, dmem_write, mem_rdata,
           load_pc, load_ifid, load_idex, load_exmem, load_memwb,
           pcmux_redirect, flush_ifid, flush_idex, flush_exmem, stall_cycles
  );

  // Pipeline/memory side.
  modport slave (
    output imem_resp, imem_rdata, mem_read_req, mem_write_req,
           dmem_resp, dmem_rdata, load_use, branch_taken,
    input  imem_read, fetch_instr, dmem_read, dmem_write, mem_rdata,
           load_pc, load_ifid, load_idex, load_exmem, load_memwb,
           pcmux_redirect, flush_ifid, flush_idex, flush_exmem, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the five-stage LC-3b pipeline.
// Optional stall performance counter enabled by defining PIPE_STALL_PERF_EN.
module pipeline_stall_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_stall_ctrl_if.master bus
);
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_i_done;
  logic [WORD_W-1:0]   r_i_hold;
  logic                r_d_done;
  logic [WORD_W-1:0]   r_d_hold;

  logic                w_i_ready;
  logic                w_d_need;
  logic                w_d_ready;
  logic                w_advance;
  logic                w_bubble;
  logic                w_redirect;
  logic [WORD_W-1:0]   w_fetch;

  assign w_i_ready  = r_i_done | bus.imem_resp;
  assign w_d_need   = bus.mem_read_req | bus.mem_write_req;
  assign w_d_ready  = ~w_d_need | r_d_done | bus.dmem_resp;
  assign w_advance  = w_i_ready & w_d_ready & ~reset;
  assign w_redirect = w_advance & bus.branch_taken;
  assign w_bubble   = w_advance & bus.load_use & ~bus.branch_taken;
  assign w_fetch    = r_i_done ? r_i_hold : bus.imem_rdata;

  assign bus.imem_read   = ~reset & ~r_i_done;
  assign bus.dmem_read   = ~reset & bus.mem_read_req & ~r_d_done;
  assign bus.dmem_write  = ~reset & bus.mem_write_req & ~r_d_done;
  assign bus.fetch_instr = w_fetch;
  assign bus.mem_rdata   = r_d_done ? r_d_hold : bus.dmem_rdata;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: wait whenever either memory holds the pipeline.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (!w_advance) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_advance)  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Latch enables, redirect and flush strobes.
  always_comb begin
    bus.load_pc        = 1'b0;
    bus.load_ifid      = 1'b0;
    bus.load_idex      = 1'b0;
    bus.load_exmem     = 1'b0;
    bus.load_memwb     = 1'b0;
    bus.pcmux_redirect = 1'b0;
    bus.flush_ifid     = 1'b0;
    bus.flush_idex     = 1'b0;
    bus.flush_exmem    = 1'b0;
    if (w_advance) begin
      bus.load_pc    = ~w_bubble;
      bus.load_ifid  = ~w_bubble;
      bus.load_idex  = 1'b1;
      bus.load_exmem = 1'b1;
      bus.load_memwb = 1'b1;
      if (w_redirect) begin
        bus.pcmux_redirect = 1'b1;
        bus.flush_ifid     = 1'b1;
        bus.flush_idex     = 1'b1;
        bus.flush_exmem    = 1'b1;
      end else if (w_bubble) begin
        bus.flush_idex = 1'b1;
      end
    end
  end

  // Response buffering; a bubble keeps the current fetch so it re-issues without refetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i_done <= 1'b0;
      r_i_hold <= '0;
      r_d_done <= 1'b0;
      r_d_hold <= '0;
    end else if (w_bubble) begin
      r_i_done <= 1'b1;
      r_i_hold <= w_fetch;
      r_d_done <= 1'b0;
    end else if (w_advance) begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      if (bus.imem_resp && !r_i_done) begin
        r_i_done <= 1'b1;
        r_i_hold <= bus.imem_rdata;
      end
      if (bus.dmem_resp && w_d_need && !r_d_done) begin
        r_d_done <= 1'b1;
        r_d_hold <= bus.dmem_rdata;
      end
    end
  end

`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;

  // Count held cycles and load-use bubbles; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)                      r_stall_cycles <= '0;
    else if (!w_advance || w_bubble) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl.
module tb_pipeline_stall_ctrl;
  // Strobe vector bit positions, MSB first:
  // load_pc load_ifid load_idex load_exmem load_memwb pcmux fl_ifid fl_idex fl_exmem imem_rd dmem_rd dmem_wr
  localparam logic [11:0] L_ALL  = 12'hF80;
  localparam logic [11:0] L_BUB  = 12'h380;
  localparam logic [11:0] PCMUX  = 12'h040;
  localparam logic [11:0] FL_ALL = 12'h038;
  localparam logic [11:0] FL_IDX = 12'h010;
  localparam logic [11:0] IRD    = 12'h004;
  localparam logic [11:0] DRD    = 12'h002;
  localparam logic [11:0] DWR    = 12'h001;
  localparam logic [11:0] NONE   = 12'h000;

  typedef struct {
    logic [11:0] s;
    logic        cf;
    logic [15:0] f;
    logic        cm;
    logic [15:0] m;
    logic [31:0] st;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [31:0] stall_model;
  exp_t sb_q[$];

  pipeline_stall_ctrl_if bus_if ();

  pipeline_stall_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the expected combinational response.
  task automatic cyc(input logic rst, input logic ir, input logic [15:0] id,
                     input logic rr, input logic wr, input logic dr, input logic [15:0] dd,
                     input logic lu, input logic bt,
                     input logic [11:0] es, input logic cf, input logic [15:0] ef,
                     input logic cm, input logic [15:0] em);
    exp_t e;
    logic inc;
    @(posedge clk);
    #1;
    reset                = rst;
    bus_if.imem_resp     = ir;
    bus_if.imem_rdata    = id;
    bus_if.mem_read_req  = rr;
    bus_if.mem_write_req = wr;
    bus_if.dmem_resp     = dr;
    bus_if.dmem_rdata    = dd;
    bus_if.load_use      = lu;
    bus_if.branch_taken  = bt;
    e.s  = es;
    e.cf = cf;
    e.f  = ef;
    e.cm = cm;
    e.m  = em;
    e.st = stall_model;
    sb_q.push_back(e);
    inc = (es[11:7] == 5'b0) || (es[11:10] == 2'b0 && es[4]);
`ifdef PIPE_STALL_PERF_EN
    if (rst)      stall_model = 32'h0;
    else if (inc) stall_model = stall_model + 32'h1;
`else
    if (inc) stall_model = 32'h0;
`endif
  endtask

  // Compare DUT outputs against the oldest expectation, mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [11:0] got_s;
      e = sb_q.pop_front();
      got_s = {bus_if.load_pc, bus_if.load_ifid, bus_if.load_idex, bus_if.load_exmem,
               bus_if.load_memwb, bus_if.pcmux_redirect, bus_if.flush_ifid,
               bus_if.flush_idex, bus_if.flush_exmem, bus_if.imem_read,
               bus_if.dmem_read, bus_if.dmem_write};
      chk("strobes", 32'(got_s), 32'(e.s));
      if (e.cf) chk("fetch_instr", 32'(bus_if.fetch_instr), 32'(e.f));
      if (e.cm) chk("mem_rdata", 32'(bus_if.mem_rdata), 32'(e.m));
      chk("stall_cycles", bus_if.stall_cycles, e.st);
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    stall_model = 32'h0;
    reset = 1'b1;
    bus_if.imem_resp = 1'b0;  bus_if.imem_rdata = 16'h0;
    bus_if.mem_read_req = 1'b0; bus_if.mem_write_req = 1'b0;
    bus_if.dmem_resp = 1'b0;  bus_if.dmem_rdata = 16'h0;
    bus_if.load_use = 1'b0;   bus_if.branch_taken = 1'b0;

    // Reset for two cycles, then first fetch hits immediately.
    cyc(1, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, NONE, 0, 16'h0, 0, 16'h0);
    cyc(1, 1, 16'h9999, 1, 0, 1, 16'h0, 0, 0, NONE, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'h1234, 0, 0, 0, 16'h0, 0, 0, L_ALL | IRD, 1, 16'h1234, 0, 16'h0);

    // Split arrival: fetch at cycle 1, data read returns at cycle 4.
    cyc(0, 1, 16'hA5A5, 1, 0, 0, 16'h0, 0, 0, IRD | DRD, 1, 16'hA5A5, 0, 16'h0);
    cyc(0, 0, 16'h0,    1, 0, 0, 16'h0, 0, 0, DRD, 1, 16'hA5A5, 0, 16'h0);
    cyc(0, 0, 16'h0,    1, 0, 0, 16'h0, 0, 0, DRD, 1, 16'hA5A5, 0, 16'h0);
    cyc(0, 0, 16'h0,    1, 0, 1, 16'hBEEF, 0, 0, L_ALL | DRD, 1, 16'hA5A5, 1, 16'hBEEF);

    // Load-use bubble then re-issue from the held instruction.
    cyc(0, 1, 16'h7777, 0, 0, 0, 16'h0, 1, 0, L_BUB | FL_IDX | IRD, 1, 16'h7777, 0, 16'h0);
    cyc(0, 0, 16'h0,    0, 0, 0, 16'h0, 0, 0, L_ALL, 1, 16'h7777, 0, 16'h0);

    // Branch beats load-use.
    cyc(0, 1, 16'h1111, 0, 0, 0, 16'h0, 1, 1, L_ALL | PCMUX | FL_ALL | IRD, 1, 16'h1111, 0, 16'h0);

    // Simultaneous responses advance unbuffered; next fetch must be re-requested.
    cyc(0, 1, 16'h3333, 1, 0, 1, 16'h4444, 0, 0, L_ALL | IRD | DRD, 1, 16'h3333, 1, 16'h4444);
    cyc(0, 0, 16'h0,    0, 0, 0, 16'h0, 0, 0, IRD, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'h5555, 0, 0, 0, 16'h0, 0, 0, L_ALL | IRD, 1, 16'h5555, 0, 16'h0);

    // Branch waits for its outstanding wrong-path fetch before redirecting.
    cyc(0, 0, 16'h0,    0, 0, 0, 16'h0, 0, 1, IRD, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'h6666, 0, 0, 0, 16'h0, 0, 1, L_ALL | PCMUX | FL_ALL | IRD, 1, 16'h6666, 0, 16'h0);

    // Reset mid-write wait abandons the access; write re-asserts afterwards.
    cyc(0, 1, 16'h2222, 0, 1, 0, 16'h0, 0, 0, IRD | DWR, 1, 16'h2222, 0, 16'h0);
    cyc(1, 0, 16'h0,    0, 1, 1, 16'h0, 0, 0, NONE, 0, 16'h0, 0, 16'h0);
    cyc(0, 0, 16'h0,    0, 1, 0, 16'h0, 0, 0, IRD | DWR, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'h8888, 0, 1, 1, 16'h0, 0, 0, L_ALL | IRD | DWR, 1, 16'h8888, 0, 16'h0);

    // Ten held cycles waiting on instruction memory, then a hit.
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, IRD, 0, 16'h0, 0, 16'h0);
    cyc(0, 1, 16'hC0DE, 0, 0, 0, 16'h0, 0, 0, L_ALL | IRD, 1, 16'hC0DE, 0, 16'h0);
    cyc(0, 1, 16'hD00D, 0, 0, 0, 16'h0, 0, 0, L_ALL | IRD, 1, 16'hD00D, 0, 16'h0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
